// File: rtl/cci_mpf_prim_rob_multi.sv
// Multi-slot reorder buffer: one allocation reserves 1..MAX_ALLOC contiguous slots,
// payloads complete in any order and drain in allocation order with per-beat meta.
module cci_mpf_prim_rob_multi #(
  parameter int N_ENTRIES      = 64,
  parameter int N_DATA_BITS    = 512,
  parameter int N_META_BITS    = 16,
  parameter int MAX_ALLOC      = 4,
  parameter int MIN_FREE_SLOTS = MAX_ALLOC,
  localparam int IW = $clog2(N_ENTRIES),
  localparam int CW = $clog2(MAX_ALLOC),
  localparam int MW = (N_META_BITS > 0) ? N_META_BITS : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enq_en,
  input  logic [CW-1:0]          enqAllocCnt,
  input  logic [MW-1:0]          enqMeta,
  output logic                   notFull,
  output logic [IW-1:0]          enqIdx,
  input  logic                   enqData_en,
  input  logic [IW-1:0]          enqDataIdx,
  input  logic [N_DATA_BITS-1:0] enqData,
  input  logic                   deq_en,
  output logic                   notEmpty,
  output logic [N_DATA_BITS-1:0] first,
  output logic [MW-1:0]          firstMeta,
  output logic [CW-1:0]          firstBeat,
  output logic                   firstLast
);

  typedef struct packed {
    logic [N_DATA_BITS-1:0] data;
    logic [MW-1:0]          meta;
    logic [CW-1:0]          beat;
    logic                   last;
  } out_t;

  logic [IW:0]            newest_q, oldest_q, occ, free_cnt;
  logic [IW-1:0]          old_idx, old_nxt;
  logic [N_ENTRIES-1:0]   valid_q;
  logic [CW-1:0]          beat_q [N_ENTRIES];
  logic                   last_q [N_ENTRIES];
  logic [IW-1:0]          slot_off [N_ENTRIES];
  logic [IW-1:0]          cnt_ext;
  logic [N_DATA_BITS-1:0] mem [N_ENTRIES];

  logic                   oldest_rdy_q, oldest_rdy_d, xfer;
  logic                   clr_vld_q;
  logic [IW-1:0]          clr_idx_q;
  logic                   rd_vld_q;
  logic [N_DATA_BITS-1:0] rd_data_q;
  logic [CW-1:0]          rd_beat_q;
  logic                   rd_last_q;
  logic [MW-1:0]          meta_hold_q;

  out_t                   fifo_q [4];
  logic [1:0]             fwr_q, frd_q;
  logic [2:0]             fcnt_q;
  logic                   push, pop;

  assign occ      = newest_q - oldest_q;
  assign free_cnt = (IW+1)'(N_ENTRIES) - occ;
  assign notFull  = (free_cnt >= (IW+1)'(MIN_FREE_SLOTS));
  assign enqIdx   = newest_q[IW-1:0];
  assign old_idx  = oldest_q[IW-1:0];
  assign old_nxt  = old_idx + IW'(1);
  assign cnt_ext  = {{(IW-CW){1'b0}}, enqAllocCnt};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      newest_q <= '0;
      oldest_q <= '0;
    end else begin
      if (enq_en) newest_q <= newest_q + {{(IW+1-CW){1'b0}}, enqAllocCnt} + (IW+1)'(1);
      if (xfer)   oldest_q <= oldest_q + (IW+1)'(1);
    end
  end

  // Offset of each slot from the allocation base selects the slots being reserved.
  always_comb begin
    for (int e = 0; e < N_ENTRIES; e++) slot_off[e] = IW'(e) - newest_q[IW-1:0];
  end

  always_ff @(posedge clk) begin
    for (int e = 0; e < N_ENTRIES; e++) begin
      if (enq_en && slot_off[e] <= cnt_ext) begin
        beat_q[e] <= slot_off[e][CW-1:0];
        last_q[e] <= (slot_off[e][CW-1:0] == enqAllocCnt);
      end
    end
    if (enqData_en) mem[enqDataIdx] <= enqData;
  end

  // A drained slot's valid bit clears one cycle after its transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q   <= '0;
      clr_vld_q <= 1'b0;
      clr_idx_q <= '0;
    end else begin
      clr_vld_q <= xfer;
      clr_idx_q <= old_idx;
      if (clr_vld_q)  valid_q[clr_idx_q]  <= 1'b0;
      if (enqData_en) valid_q[enqDataIdx] <= 1'b1;
    end
  end

  // FIFO may accept a transfer only with room for it and the one already in flight.
  assign xfer         = oldest_rdy_q && (fcnt_q <= 3'd2);
  assign oldest_rdy_d = xfer ? valid_q[old_nxt] : valid_q[old_idx];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      oldest_rdy_q <= 1'b0;
      rd_vld_q     <= 1'b0;
    end else begin
      oldest_rdy_q <= oldest_rdy_d;
      rd_vld_q     <= xfer;
    end
  end

  always_ff @(posedge clk) begin
    if (xfer) begin
      rd_data_q <= mem[old_idx];
      rd_beat_q <= beat_q[old_idx];
      rd_last_q <= last_q[old_idx];
    end
  end

  if (N_META_BITS > 0) begin : g_meta
    logic [MW-1:0] meta_mem [N_ENTRIES];
    // Beat 0 refreshes the hold register; later beats of the same allocation reuse it.
    always_ff @(posedge clk) begin
      if (enq_en) meta_mem[newest_q[IW-1:0]] <= enqMeta;
      if (xfer && beat_q[old_idx] == '0) meta_hold_q <= meta_mem[old_idx];
    end
  end else begin : g_no_meta
    assign meta_hold_q = '0;
  end

  assign push = rd_vld_q;
  assign pop  = deq_en && notEmpty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fwr_q  <= '0;
      frd_q  <= '0;
      fcnt_q <= '0;
    end else begin
      if (push) fwr_q <= fwr_q + 2'd1;
      if (pop)  frd_q <= frd_q + 2'd1;
      fcnt_q <= fcnt_q + 3'(push) - 3'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[fwr_q] <= '{data: rd_data_q, meta: meta_hold_q, beat: rd_beat_q, last: rd_last_q};
  end

  assign notEmpty  = (fcnt_q != 3'd0);
  assign first     = fifo_q[frd_q].data;
  assign firstMeta = fifo_q[frd_q].meta;
  assign firstBeat = fifo_q[frd_q].beat;
  assign firstLast = fifo_q[frd_q].last;

  logic [IW-1:0] wr_off;
  logic          wr_alloc;
  assign wr_off   = enqDataIdx - old_idx;
  assign wr_alloc = ({1'b0, wr_off} < occ);

  always @(negedge clk) begin
    if (!reset) begin
      if (enq_en && !notFull) $fatal(1, "enq_en with notFull low");
      if (enqData_en && (!wr_alloc || valid_q[enqDataIdx]))
        $fatal(1, "illegal data write to slot %0d", enqDataIdx);
      if (deq_en && !notEmpty) $fatal(1, "deq_en with notEmpty low");
    end
  end

endmodule

// File: tb/tb_cci_mpf_prim_rob_multi.sv
// Bench for cci_mpf_prim_rob_multi: allocation table plus scoreboard of expected beats.
module tb_cci_mpf_prim_rob_multi;
  logic         clk = 1'b0;
  logic         reset;
  logic         enq_en;
  logic [1:0]   enqAllocCnt;
  logic [15:0]  enqMeta;
  logic         notFull;
  logic [5:0]   enqIdx;
  logic         enqData_en;
  logic [5:0]   enqDataIdx;
  logic [511:0] enqData;
  logic         deq_en = 1'b0;
  logic         notEmpty;
  logic [511:0] first;
  logic [15:0]  firstMeta;
  logic [1:0]   firstBeat;
  logic         firstLast;

  cci_mpf_prim_rob_multi dut (
    .clk(clk), .reset(reset), .enq_en(enq_en), .enqAllocCnt(enqAllocCnt), .enqMeta(enqMeta),
    .notFull(notFull), .enqIdx(enqIdx), .enqData_en(enqData_en), .enqDataIdx(enqDataIdx),
    .enqData(enqData), .deq_en(deq_en), .notEmpty(notEmpty), .first(first),
    .firstMeta(firstMeta), .firstBeat(firstBeat), .firstLast(firstLast)
  );

  always #5 clk = ~clk;

  typedef struct { logic [511:0] data; logic [15:0] meta; logic [1:0] beat; logic last; } exp_t;
  typedef struct { int cnt; logic [15:0] meta; int exp_idx; } vec_t;

  exp_t         sb [$];
  exp_t         e;
  vec_t         vt [6];
  logic [511:0] slot_data [64];
  int           n_chk = 0, n_pass = 0;
  int           tb_newest = 0;
  int           seq = 0;
  logic         deq_hold = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic alloc(input int cnt, input logic [15:0] meta, input int exp_idx);
    int k;
    logic [511:0] d;
    k = 0;
    while (!notFull && k < 200) begin step(1); k++; end
    chk("alloc_notFull", 64'(notFull), 64'd1);
    enq_en = 1'b1; enqAllocCnt = 2'(cnt); enqMeta = meta;
    chk("enqIdx", 64'(enqIdx), 64'(exp_idx));
    for (int b = 0; b <= cnt; b++) begin
      int idx;
      idx = (tb_newest + b) % 64;
      seq++;
      d = {16{24'(seq), 8'(idx)}};
      slot_data[idx] = d;
      sb.push_back('{data: d, meta: meta, beat: 2'(b), last: (b == cnt)});
    end
    tb_newest = (tb_newest + cnt + 1) % 128;
    step(1);
    enq_en = 1'b0;
  endtask

  task automatic wr(input int idx);
    enqData_en = 1'b1; enqDataIdx = 6'(idx); enqData = slot_data[idx];
    step(1);
    enqData_en = 1'b0;
  endtask

  task automatic drain(input string nm);
    int k;
    k = 0;
    deq_hold = 1'b1;
    while ((sb.size() != 0 || notEmpty) && k < 300) begin step(1); k++; end
    chk(nm, 64'(sb.size()), 64'd0);
  endtask

  always @(posedge clk) begin
    #1;
    deq_en = deq_hold && notEmpty && !reset;
  end

  // Each popped beat is compared against the front of the scoreboard.
  always @(negedge clk) begin
    if (!reset && deq_en && notEmpty) begin
      if (sb.size() == 0) chk("unexpected_beat", 64'd1, 64'd0);
      else begin
        e = sb.pop_front();
        chk("beat_data_lo", first[63:0], e.data[63:0]);
        chk("beat_data_hi", first[511:448], e.data[511:448]);
        chk("beat_meta", 64'(firstMeta), 64'(e.meta));
        chk("beat_num", 64'(firstBeat), 64'(e.beat));
        chk("beat_last", 64'(firstLast), 64'(e.last));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    vt[0] = '{3, 16'h0055, 0};
    vt[1] = '{0, 16'h000A, 4};
    vt[2] = '{0, 16'h000B, 5};
    vt[3] = '{0, 16'h000C, 6};
    vt[4] = '{0, 16'h000D, 7};
    vt[5] = '{3, 16'h0062, 62};

    reset = 1'b1; enq_en = 1'b0; enqAllocCnt = '0; enqMeta = '0;
    enqData_en = 1'b0; enqDataIdx = '0; enqData = '0;
    #12;
    chk("rst_notFull", 64'(notFull), 64'd1);
    chk("rst_notEmpty", 64'(notEmpty), 64'd0);
    chk("rst_enqIdx", 64'(enqIdx), 64'd0);
    @(negedge clk); reset = 1'b0;
    step(1);

    // Multi-beat allocation written in reverse order.
    alloc(vt[0].cnt, vt[0].meta, vt[0].exp_idx);
    deq_hold = 1'b1;
    wr(3); wr(2); wr(1);
    step(4);
    chk("rev_hold_empty", 64'(notEmpty), 64'd0);
    wr(0);
    drain("rev_drain");

    // In-order singles with latency measurement on the first write.
    deq_hold = 1'b0;
    for (int i = 1; i <= 4; i++) alloc(vt[i].cnt, vt[i].meta, vt[i].exp_idx);
    wr(4);
    @(posedge clk); @(negedge clk); chk("lat_T1", 64'(notEmpty), 64'd0);
    @(posedge clk); @(negedge clk); chk("lat_T2", 64'(notEmpty), 64'd0);
    @(posedge clk); @(negedge clk); chk("lat_T3", 64'(notEmpty), 64'd1);
    @(posedge clk); #1;
    wr(5); wr(6); wr(7);
    drain("singles_drain");

    // Advance the ring to slot 62, then wrap a 4-beat allocation.
    deq_hold = 1'b1;
    for (int g = 0; g < 13; g++) begin
      base = tb_newest;
      alloc(3, 16'h0100 + 16'(g), base % 64);
      for (int b = 0; b < 4; b++) wr((base + b) % 64);
    end
    base = tb_newest;
    alloc(1, 16'h0200, base % 64);
    wr(base % 64); wr((base + 1) % 64);
    drain("adv_drain");
    alloc(vt[5].cnt, vt[5].meta, vt[5].exp_idx);
    wr(0); wr(63); wr(1); wr(62);
    drain("wrap_drain");

    // Free-slot threshold.
    deq_hold = 1'b0;
    base = tb_newest;
    for (int g = 0; g < 15; g++) alloc(3, 16'h0300 + 16'(g), tb_newest % 64);
    chk("thr_free4", 64'(notFull), 64'd1);
    alloc(0, 16'h03FF, tb_newest % 64);
    chk("thr_free3", 64'(notFull), 64'd0);
    wr(base % 64);
    @(posedge clk); @(negedge clk); chk("thr_xfer_cycle", 64'(notFull), 64'd0);
    @(posedge clk); @(negedge clk); chk("thr_after_xfer", 64'(notFull), 64'd1);
    @(posedge clk); #1;
    deq_hold = 1'b1;
    for (int k = 1; k <= 60; k++) wr((base + k) % 64);
    drain("thr_drain");

    // Backpressure: FIFO stops at 4, oldest advances exactly 4.
    deq_hold = 1'b0;
    base = tb_newest;
    for (int i = 0; i < 8; i++) alloc(0, 16'h0400 + 16'(i), tb_newest % 64);
    for (int i = 0; i < 8; i++) wr((base + i) % 64);
    step(20);
    chk("bp_fifo_cnt", 64'(dut.fcnt_q), 64'd4);
    chk("bp_oldest", 64'(dut.oldest_q), 64'((base + 4) % 128));
    chk("bp_notEmpty", 64'(notEmpty), 64'd1);
    drain("bp_drain");

    // Asynchronous reset mid-burst.
    deq_hold = 1'b0;
    base = tb_newest;
    for (int i = 0; i < 5; i++) alloc(0, 16'h0500 + 16'(i), tb_newest % 64);
    for (int i = 0; i < 5; i++) wr((base + i) % 64);
    step(2);
    @(negedge clk); #2;
    reset = 1'b1;
    #1;
    chk("arst_notEmpty", 64'(notEmpty), 64'd0);
    chk("arst_notFull", 64'(notFull), 64'd1);
    chk("arst_enqIdx", 64'(enqIdx), 64'd0);
    sb.delete();
    tb_newest = 0;
    @(posedge clk); @(posedge clk); @(negedge clk); #2;
    reset = 1'b0;
    @(posedge clk); #1;
    alloc(0, 16'h0077, 0);
    wr(0);
    drain("arst_roundtrip");
    chk("final_empty", 64'(notEmpty), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
